fpadd_rr_sched: RTL

//  Shares one combinational FP32 adder (sum = a + b, IEEE-754 single-precision

---
 rtl/fpadd_rr_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fpadd_rr_sched.sv
// fpadd_rr_sched: one combinational FP32 adder shared among NREQ requesters.
// A round-robin arbiter grants one operand pair at a time; the sum is captured
// in a register and returned with the requester index over valid/ready.
// Optional feature macro: FPADD_SCHED_SUB_EN (honour req_sub, computing a - b).
module fpadd_rr_sched #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            r_state, w_state_nx;
    logic [ID_W-1:0]   r_rr, r_id, r_rsp_id, w_win;
    logic [31:0]       r_op_a, r_op_b, r_rsp_sum, w_sel_a, w_sel_b, w_op_b;
    logic              r_rsp_valid, w_any, w_grant;
    int                w_idx;

    // Round-robin search starting at r_rr, wrapping modulo NREQ
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = ID_W'(w_idx);
            end
        end
    end

    assign w_sel_a = req_a[32*w_win +: 32];
    assign w_sel_b = req_b[32*w_win +: 32];
`ifdef FPADD_SCHED_SUB_EN
    assign w_op_b = {w_sel_b[31] ^ req_sub[w_win], w_sel_b[30:0]};
`else
    // req_sub stays on the port so both builds share one interface
    logic w_unused_sub;
    assign w_unused_sub = ^req_sub;
    assign w_op_b = w_sel_b;
`endif

    // Next state and grant; a grant is only possible while no result is pending
    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_grant    = 1'b1;
                w_state_nx = S_EXEC;
            end
            S_EXEC: w_state_nx = S_RESP;
            S_RESP: if (rsp_ready) begin
                w_grant    = w_any;
                w_state_nx = w_any ? S_EXEC : S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (rst) w_grant = 1'b0;
        req_ready = '0;
        if (w_grant) req_ready[w_win] = 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // FP32 adder on the latched operands: align, add/sub, normalise, round-to-nearest-even.
    // Denormal inputs and results are flushed to zero.
    logic [31:0]       w_x, w_y, w_sum;
    logic [7:0]        w_ex, w_ey, w_d;
    logic [23:0]       w_mx, w_my;
    logic [53:0]       w_shf;
    logic [26:0]       w_big, w_sml, w_norm;
    logic [27:0]       w_raw;
    logic [4:0]        w_lz;
    logic              w_found, w_up;
    logic [24:0]       w_mr;
    logic signed [9:0] w_exp;
    always_comb begin
        w_x = r_op_a;
        w_y = r_op_b;
        if (r_op_b[30:0] > r_op_a[30:0]) begin
            w_x = r_op_b;
            w_y = r_op_a;
        end
        w_ex  = w_x[30:23];
        w_ey  = w_y[30:23];
        w_mx  = (w_ex == 8'd0) ? 24'd0 : {1'b1, w_x[22:0]};
        w_my  = (w_ey == 8'd0) ? 24'd0 : {1'b1, w_y[22:0]};
        w_d   = w_ex - w_ey;
        w_big = {w_mx, 3'b000};
        // the low half of w_shf holds the bits shifted out, folded into sticky
        w_shf = {w_my, 30'd0} >> w_d;
        w_sml = w_shf[53:27];
        w_sml[0] = w_sml[0] | (|w_shf[26:0]);
        if (w_d > 8'd26) w_sml = {26'd0, |w_my};
        w_exp   = $signed({2'b00, w_ex});
        w_lz    = '0;
        w_found = 1'b0;
        if (w_x[31] == w_y[31]) w_raw = {1'b0, w_big} + {1'b0, w_sml};
        else                    w_raw = {1'b0, w_big} - {1'b0, w_sml};
        if (w_raw[27]) begin
            w_norm    = w_raw[27:1];
            w_norm[0] = w_raw[1] | w_raw[0];
            w_exp     = w_exp + 10'sd1;
        end else begin
            for (int k = 0; k < 27; k++) begin
                if (!w_found && w_raw[26-k]) begin
                    w_found = 1'b1;
                    w_lz    = 5'(k);
                end
            end
            w_norm = w_raw[26:0] << w_lz;
            w_exp  = w_exp - $signed({5'd0, w_lz});
        end
        w_up = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
        w_mr = {1'b0, w_norm[26:3]} + {24'd0, w_up};
        if (w_mr[24]) w_exp = w_exp + 10'sd1;
        w_sum = '0;
        if (w_ex == 8'hFF) begin
            // larger magnitude is Inf or NaN; Inf - Inf gives NaN
            if (w_x[22:0] != 23'd0 || (w_ey == 8'hFF && w_x[31] != w_y[31])) w_sum = 32'h7FC00000;
            else w_sum = {w_x[31], 8'hFF, 23'd0};
        end else if (w_raw == 28'd0) begin
            w_sum = {w_x[31] & w_y[31], 31'd0};
        end else if (w_exp >= 10'sd255) begin
            w_sum = {w_x[31], 8'hFF, 23'd0};
        end else if (w_exp <= 10'sd0) begin
            w_sum = {w_x[31], 31'd0};
        end else begin
            w_sum = {w_x[31], w_exp[7:0], w_mr[24] ? w_mr[23:1] : w_mr[22:0]};
        end
    end

    // Operand latch at grant, result capture in EXEC, release on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr        <= '0;
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
        end else begin
            if (w_grant) begin
                r_op_a <= w_sel_a;
                r_op_b <= w_op_b;
                r_id   <= w_win;
                r_rr   <= (w_win == ID_W'(NREQ-1)) ? '0 : w_win + 1'b1;
            end
            if (r_state == S_EXEC) begin
                r_rsp_sum   <= w_sum;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign busy      = (r_state != S_IDLE);
endmodule
